// File: rtl/grid_cursor_if.sv
`default_nettype none
// ============================================================================
//  Module   : grid_cursor_if
//  Brief    : Button/jump inputs and cursor outputs of the grid cursor controller.
//  Revision : 1.0
// ============================================================================
interface grid_cursor_if #(
    parameter int IDX_W = 4
);
    logic             tick;
    logic             btn_up;
    logic             btn_down;
    logic             btn_left;
    logic             btn_right;
    logic             level_sel;
    logic             board_lock;
    logic             jump_valid;
    logic [IDX_W-1:0] jump_idx;
    logic [IDX_W-1:0] board_idx;
    logic [IDX_W-1:0] tile_idx;
    logic [2:0]       board_row;
    logic [2:0]       board_col;
    logic [2:0]       tile_row;
    logic [2:0]       tile_col;
    logic             moved;

    modport master (
        output tick, btn_up, btn_down, btn_left, btn_right,
        output level_sel, board_lock, jump_valid, jump_idx,
        input  board_idx, tile_idx, board_row, board_col, tile_row, tile_col, moved
    );

    modport slave (
        input  tick, btn_up, btn_down, btn_left, btn_right,
        input  level_sel, board_lock, jump_valid, jump_idx,
        output board_idx, tile_idx, board_row, board_col, tile_row, tile_col, moved
    );
endinterface
`default_nettype wire

// File: rtl/grid_cursor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : grid_cursor_ctrl
//  Brief    : Two-level board/tile cursor navigation with press-then-auto-repeat.
//  Revision : 1.0
// ============================================================================
module grid_cursor_ctrl #(
    parameter int GRID_DIM      = 3,
    parameter int IDX_W         = 4,
    parameter int WRAP          = 0,
    parameter int REPEAT_DELAY  = 24,
    parameter int REPEAT_PERIOD = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    grid_cursor_if.slave  bus
);

    localparam int c_CELLS   = GRID_DIM * GRID_DIM;
    localparam int c_LUT     = 2 ** IDX_W;
    localparam int c_CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [2:0]         c_LAST   = 3'(GRID_DIM - 1);
    localparam logic [c_CNT_W-1:0] c_DELAY  = c_CNT_W'(REPEAT_DELAY);
    localparam logic [c_CNT_W-1:0] c_PERIOD = c_CNT_W'(REPEAT_PERIOD);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    state_t             state_q;
    dir_t               dir_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [2:0]         board_row_q, board_col_q, tile_row_q, tile_col_q;
    logic [2:0]         board_row_d, board_col_d, tile_row_d, tile_col_d;
    logic               moved_q;

    dir_t       w_dir;
    logic       w_fire;
    logic       w_changed;
    logic [2:0] w_step_row, w_step_col;

    // Linear index -> (row, col) table built at elaboration; entries past the grid are invalid.
    logic [2:0] w_lut_row [c_LUT];
    logic [2:0] w_lut_col [c_LUT];
    logic       w_lut_ok  [c_LUT];

    for (genvar k = 0; k < c_LUT; k++) begin : g_jump_lut
        if (k < c_CELLS) begin : g_valid
            assign w_lut_row[k] = 3'(k / GRID_DIM);
            assign w_lut_col[k] = 3'(k % GRID_DIM);
            assign w_lut_ok[k]  = 1'b1;
        end else begin : g_invalid
            assign w_lut_row[k] = 3'd0;
            assign w_lut_col[k] = 3'd0;
            assign w_lut_ok[k]  = 1'b0;
        end
    end

    function automatic logic [2:0] f_dec(input logic [2:0] v);
        if (v != 3'd0) return v - 3'd1;
        return (WRAP != 0) ? c_LAST : v;
    endfunction

    function automatic logic [2:0] f_inc(input logic [2:0] v);
        if (v != c_LAST) return v + 3'd1;
        return (WRAP != 0) ? 3'd0 : v;
    endfunction

    always_comb begin
        w_dir = DIR_NONE;
        if      (bus.btn_up)    w_dir = DIR_UP;
        else if (bus.btn_down)  w_dir = DIR_DOWN;
        else if (bus.btn_left)  w_dir = DIR_LEFT;
        else if (bus.btn_right) w_dir = DIR_RIGHT;
    end

    // A step fires on a fresh press, on a direction change, or when the repeat count expires.
    always_comb begin
        w_fire = 1'b0;
        if (w_dir != DIR_NONE) begin
            if (state_q == ST_IDLE || w_dir != dir_q)
                w_fire = 1'b1;
            else if (bus.tick && cnt_q == c_ONE)
                w_fire = 1'b1;
        end
    end

    always_comb begin
        w_step_row = bus.level_sel ? tile_row_q : board_row_q;
        w_step_col = bus.level_sel ? tile_col_q : board_col_q;
        case (w_dir)
            DIR_UP:    w_step_row = f_dec(w_step_row);
            DIR_DOWN:  w_step_row = f_inc(w_step_row);
            DIR_LEFT:  w_step_col = f_dec(w_step_col);
            DIR_RIGHT: w_step_col = f_inc(w_step_col);
            default:   ;
        endcase

        board_row_d = board_row_q;
        board_col_d = board_col_q;
        tile_row_d  = tile_row_q;
        tile_col_d  = tile_col_q;
        if (w_fire) begin
            if (bus.level_sel) begin
                tile_row_d = w_step_row;
                tile_col_d = w_step_col;
            end else if (!bus.board_lock) begin
                board_row_d = w_step_row;
                board_col_d = w_step_col;
            end
        end
        if (bus.jump_valid && w_lut_ok[bus.jump_idx]) begin
            board_row_d = w_lut_row[bus.jump_idx];
            board_col_d = w_lut_col[bus.jump_idx];
        end

        w_changed = (board_row_d != board_row_q) || (board_col_d != board_col_q) ||
                    (tile_row_d  != tile_row_q)  || (tile_col_d  != tile_col_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_NONE;
            cnt_q       <= '0;
            board_row_q <= 3'd0;
            board_col_q <= 3'd0;
            tile_row_q  <= 3'd0;
            tile_col_q  <= 3'd0;
            moved_q     <= 1'b0;
        end else begin
            board_row_q <= board_row_d;
            board_col_q <= board_col_d;
            tile_row_q  <= tile_row_d;
            tile_col_q  <= tile_col_d;
            moved_q     <= w_changed;

            if (w_dir == DIR_NONE) begin
                state_q <= ST_IDLE;
                dir_q   <= DIR_NONE;
                cnt_q   <= '0;
            end else if (state_q == ST_IDLE || w_dir != dir_q) begin
                state_q <= ST_HOLD;
                dir_q   <= w_dir;
                cnt_q   <= c_DELAY;
            end else if (bus.tick) begin
                if (cnt_q == c_ONE) begin
                    state_q <= ST_REPEAT;
                    cnt_q   <= c_PERIOD;
                end else if (cnt_q > c_ONE) begin
                    cnt_q   <= cnt_q - c_ONE;
                end
            end
        end
    end

    assign bus.board_idx = IDX_W'(32'(board_row_q) * 32'(GRID_DIM) + 32'(board_col_q));
    assign bus.tile_idx  = IDX_W'(32'(tile_row_q)  * 32'(GRID_DIM) + 32'(tile_col_q));
    assign bus.board_row = board_row_q;
    assign bus.board_col = board_col_q;
    assign bus.tile_row  = tile_row_q;
    assign bus.tile_col  = tile_col_q;
    assign bus.moved     = moved_q;

endmodule
`default_nettype wire
